// File: rtl/matrix_pkg.sv
// Shared definitions for the UART matrix link: frame marker, element count,
// counter width and the receive FSM state type.
package matrix_pkg;

  localparam int DEF_ROWS = 2;
  localparam int DEF_COLS = 2;
  localparam int N_ELEM   = DEF_ROWS * DEF_COLS;
  localparam int CNT_W    = $clog2(N_ELEM) + 1;

  localparam logic [7:0] START_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CHECK,
    DONE
  } rx_state_t;

endpackage

// File: rtl/rx_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Input rise to pulse high is three clock edges.
module rx_edge_sync (
  input  logic bclk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      pulse   <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/rx_to_mem.sv
// Receives a framed byte stream (START, A elements, B elements) and writes the
// elements into the A/B operand memories. Define RX_CHECKSUM_EN for a trailing
// mod-256 checksum byte checked before load_done.
module rx_to_mem
  import matrix_pkg::*;
#(
  parameter int          ROWS       = 2,
  parameter int          COLS       = 2,
  parameter int          DW         = 8,
  parameter int          AW         = 6,
  parameter logic [DW-1:0] START_BYTE = matrix_pkg::START_BYTE
) (
  input  logic          bclk,
  input  logic          rst,
  input  logic          rx_status,
  input  logic [DW-1:0] rx_byte,
  input  logic          abort,
  output logic          wr_en_a,
  output logic          wr_en_b,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          load_done,
  output logic          frame_err
);

  localparam int ELEMS = ROWS * COLS;
  localparam int CW    = $clog2(ELEMS) + 1;

  logic          byte_evt;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_a_d, wr_b_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_d;
  logic          busy_d, done_d, err_d;
  logic          last_elem;
`ifdef RX_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  rx_edge_sync u_sync (
    .bclk  (bclk),
    .rst   (rst),
    .din   (rx_status),
    .pulse (byte_evt)
  );

  assign last_elem = (cnt_q == CW'(ELEMS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_a_d  = 1'b0;
    wr_b_d  = 1'b0;
    addr_d  = wr_addr;
    data_d  = wr_data;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = frame_err;
`ifdef RX_CHECKSUM_EN
    sum_d   = sum_q;
`else
    // A new byte landing while the previous strobe is still out is an overrun.
    if (byte_evt && (wr_en_a || wr_en_b)) err_d = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (byte_evt && rx_byte == START_BYTE) begin
          state_d = LOAD_A;
          cnt_d   = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
`ifdef RX_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD_A, LOAD_B: begin
        if (byte_evt) begin
          wr_a_d = (state_q == LOAD_A);
          wr_b_d = (state_q == LOAD_B);
          addr_d = AW'(cnt_q);
          data_d = rx_byte;
`ifdef RX_CHECKSUM_EN
          sum_d  = sum_q + rx_byte;
`endif
          if (last_elem) begin
            cnt_d = '0;
            if (state_q == LOAD_A) begin
              state_d = LOAD_B;
            end else begin
`ifdef RX_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
`ifdef RX_CHECKSUM_EN
        if (byte_evt) begin
          if (rx_byte == sum_q) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
`else
        state_d = IDLE;
        busy_d  = 1'b0;
`endif
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides everything, including a byte arriving in the same cycle.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      wr_a_d  = 1'b0;
      wr_b_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = frame_err;
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_a   <= 1'b0;
      wr_en_b   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
`ifdef RX_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_a   <= wr_a_d;
      wr_en_b   <= wr_b_d;
      wr_addr   <= addr_d;
      wr_data   <= data_d;
      busy      <= busy_d;
      load_done <= done_d;
      frame_err <= err_d;
`ifdef RX_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_rx_to_mem.sv
// Self-checking bench for rx_to_mem: random frames checked against a
// frame-level reference model of the expected memory writes.
module tb_rx_to_mem;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 8;
  localparam int AW   = 6;
  localparam int N    = ROWS * COLS;

  logic          bclk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_status = 1'b0;
  logic [DW-1:0] rx_byte = '0;
  logic          abort = 1'b0;
  logic          wr_en_a, wr_en_b, busy, load_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  rx_to_mem #(
    .ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .START_BYTE(8'hA5)
  ) dut (
    .bclk      (bclk),
    .rst       (rst),
    .rx_status (rx_status),
    .rx_byte   (rx_byte),
    .abort     (abort),
    .wr_en_a   (wr_en_a),
    .wr_en_b   (wr_en_b),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  initial forever #5 bclk = ~bclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe recorded as {bank, addr, data}.
  logic [14:0] act_q[$];
  int   cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;
  int   wide_err = 0, both_err = 0;
  logic prev_wr = 1'b0, prev_done = 1'b0;

  always @(negedge bclk) begin
    if (wr_en_a) begin act_q.push_back({1'b0, wr_addr, wr_data}); last_wr_cyc = cyc; end
    if (wr_en_b) begin act_q.push_back({1'b1, wr_addr, wr_data}); last_wr_cyc = cyc; end
    if (wr_en_a && wr_en_b) both_err++;
    if ((wr_en_a || wr_en_b) && prev_wr) wide_err++;
    if (load_done && prev_done) wide_err++;
    if (load_done) begin done_cnt++; done_cyc = cyc; end
    prev_wr   = wr_en_a || wr_en_b;
    prev_done = load_done;
    cyc++;
  end

  // Reference model: frame = A5, 2N data bytes (first N to A, rest to B),
  // optionally a trailing sum byte.
  logic [14:0] exp_q[$];
  bit          m_in = 1'b0;
  int          m_idx = 0;
  logic [7:0]  m_sum = '0;
  int          exp_done = 0;
  logic        exp_err = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    if (!m_in) begin
      if (b == 8'hA5) begin
        m_in = 1'b1; m_idx = 0; m_sum = '0; exp_err = 1'b0;
      end
    end else if (m_idx < 2 * N) begin
      exp_q.push_back({(m_idx >= N) ? 1'b1 : 1'b0, 6'(m_idx % N), b});
      m_sum = m_sum + b;
      m_idx++;
`ifndef RX_CHECKSUM_EN
      if (m_idx == 2 * N) begin exp_done++; m_in = 1'b0; end
`endif
    end else begin
      if (b == m_sum) exp_done++;
      else exp_err = 1'b1;
      m_in = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    @(negedge bclk);
    rx_byte   = b;
    rx_status = 1'b1;
    repeat (4) @(negedge bclk);
    rx_status = 1'b0;
    repeat (4) @(negedge bclk);
  endtask

  task automatic send_frame(input logic [7:0] d[2*N]);
    logic [7:0] s;
    s = '0;
    send(8'hA5);
    for (int i = 0; i < 2 * N; i++) begin
      send(d[i]);
      s = s + d[i];
    end
`ifdef RX_CHECKSUM_EN
    send(s);
`endif
  endtask

  task automatic rand_data(output logic [7:0] d[2*N]);
    for (int i = 0; i < 2 * N; i++) d[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_results(input string tag);
    repeat (3) @(negedge bclk);
    chk({tag, "_nwr"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_err));
    chk({tag, "_width"}, wide_err + both_err, 0);
`ifndef RX_CHECKSUM_EN
    if (exp_done > 0) chk({tag, "_donelat"}, done_cyc, last_wr_cyc + 1);
`endif
    act_q.delete(); exp_q.delete();
    done_cnt = 0; exp_done = 0; wide_err = 0; both_err = 0;
  endtask

  initial begin
    logic [7:0] d[2*N];
    logic [7:0] g;
    bit         seen;

    // Reset state
    repeat (2) @(negedge bclk);
    chk("rst_outs", {wr_en_a, wr_en_b, wr_addr, wr_data, busy, load_done, frame_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge bclk);
    chk("idle_busy", 32'(busy), 0);

    // 1: fixed frame 1..8
    for (int i = 0; i < 2 * N; i++) d[i] = 8'(i + 1);
    send_frame(d);
    chk("t1_busy_after", 32'(busy), 0);
    check_results("t1");

    // 2: garbage ignored before the start byte
    send(8'h00); send(8'hFF); send(8'h13);
    for (int k = 0; k < 3; k++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send(g);
    end
    chk("t2_busy_garbage", 32'(busy), 0);
    rand_data(d);
    send_frame(d);
    check_results("t2");

    // 3: abort after three A bytes
    rand_data(d);
    send(8'hA5);
    for (int i = 0; i < 3; i++) send(d[i]);
    chk("t3_busy_mid", 32'(busy), 1);
    @(negedge bclk); abort = 1'b1;
    @(negedge bclk); abort = 1'b0;
    chk("t3_busy_abort", 32'(busy), 0);
    m_in = 1'b0;
    repeat (20) @(negedge bclk);
    check_results("t3a");
    rand_data(d);
    send_frame(d);
    check_results("t3b");

    // 4: async reset while a B write strobe is out
    rand_data(d);
    send(8'hA5);
    for (int i = 0; i < N + 2; i++) send(d[i]);
    @(negedge bclk);
    rx_byte = d[N+2]; rx_status = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge bclk); #1;
      if (wr_en_b) seen = 1'b1;
    end
    chk("t4_strobe_seen", 32'(seen), 1);
    chk("t4_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_outs", {wr_en_a, wr_en_b, wr_addr, wr_data, busy, load_done, frame_err}, 0);
    rx_status = 1'b0;
    @(negedge bclk); rst = 1'b0;
    m_in = 1'b0;
    check_results("t4a");
    rand_data(d);
    send_frame(d);
    check_results("t4b");

    // 6: START value as data
    rand_data(d);
    d[1] = 8'hA5;
    send_frame(d);
    check_results("t6");

`ifdef RX_CHECKSUM_EN
    // 5: checksum good then bad
    send(8'hA5);
    for (int i = 0; i < 2 * N; i++) send(8'(i + 1));
    send(8'h24);
    check_results("t5a");
    send(8'hA5);
    for (int i = 0; i < 2 * N; i++) send(8'(i + 1));
    send(8'h25);
    check_results("t5b");
    rand_data(d);
    send_frame(d);
    check_results("t5c");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
